// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, 1-cycle registered ROM interface and a one-word hold buffer.
// Optional halt-on-opcode freeze is enabled by defining FETCH_HALT_EN.
module fetch_unit #(
    parameter int unsigned             ADDR_W    = 16,
    parameter int unsigned             DATA_W    = 32,
    parameter logic [ADDR_W-1:0]       STEP      = ADDR_W'(1),
    parameter logic [ADDR_W-1:0]       RESET_PC  = '0,
    parameter logic [DATA_W-1:0]       HALT_WORD = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_q,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    output logic [31:0]       retired_cnt,
    output logic              halted
);

`ifdef FETCH_HALT_EN
    localparam logic HALT_EN = 1'b1;
`else
    localparam logic HALT_EN = 1'b0;
`endif

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] f_pc_q, f_pc_d;
    logic              f_v_q, f_v_d;
    logic              held_q, held_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              halted_q, halted_d;
    logic [31:0]       cnt_q, cnt_d;

    logic accept;
    logic advance;
    logic halt_hit;

    assign imem_addr   = pc_q;
    assign instr       = held_q ? hold_q : imem_q;
    assign instr_pc    = f_pc_q;
    assign instr_valid = f_v_q;
    assign retired_cnt = cnt_q;
    assign halted      = halted_q;

    assign accept   = f_v_q & ~stall;
    assign advance  = ~stall & ~halted_q & ~branch_valid;
    assign halt_hit = HALT_EN & accept & (instr == HALT_WORD);

    // Next-state: branch > halt > advance > hold; the word accepted this cycle always counts.
    always_comb begin
        pc_d     = pc_q;
        f_pc_d   = f_pc_q;
        f_v_d    = f_v_q;
        held_d   = held_q;
        hold_d   = hold_q;
        halted_d = halted_q;
        cnt_d    = cnt_q;

        if (accept) begin
            cnt_d = cnt_q + 32'd1;
        end

        if (branch_valid) begin
            pc_d     = branch_target;
            f_v_d    = 1'b0;
            held_d   = 1'b0;
            halted_d = 1'b0;
        end else if (halt_hit) begin
            halted_d = 1'b1;
            f_v_d    = 1'b0;
            held_d   = 1'b0;
        end else if (advance) begin
            f_pc_d = pc_q;
            f_v_d  = 1'b1;
            held_d = 1'b0;
            pc_d   = pc_q + STEP;
        end else if (f_v_q && !held_q) begin
            // ROM output moves on to mem[pc] next cycle, so capture the stalled word now
            hold_d = imem_q;
            held_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            f_pc_q   <= RESET_PC;
            f_v_q    <= 1'b0;
            held_q   <= 1'b0;
            hold_q   <= '0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            pc_q     <= pc_d;
            f_pc_q   <= f_pc_d;
            f_v_q    <= f_v_d;
            held_q   <= held_d;
            hold_q   <= hold_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
